// File: rtl/myled_pkg.sv
// Shared constants for the myled_pwm_axil LED peripheral:
// register byte offsets, CTRL bit indices, AXI responses and a strobe merge helper.
package myled_pkg;

    localparam logic [31:0] CTRL_OFS     = 32'h00;
    localparam logic [31:0] DIRECT_OFS   = 32'h04;
    localparam logic [31:0] PRESCALE_OFS = 32'h08;
    localparam logic [31:0] BLINK_OFS    = 32'h0C;
    localparam logic [31:0] DUTY_BASE    = 32'h10;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_PWM   = 1;
    localparam int CTRL_BLINK = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/myled_pwm_core.sv
// Prescaler, PWM counter, blink phase and the registered LED drive
// for the myled_pwm_axil peripheral.
module myled_pwm_core #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         pwm_mode,
    input  logic                         blink_en,
    input  logic [NUM_LEDS-1:0]          direct,
    input  logic [15:0]                  prescale,
    input  logic [15:0]                  blink_period,
    input  logic [NUM_LEDS*PWM_BITS-1:0] duty,
    input  logic                         presc_clr,
    input  logic                         blink_set,
    output logic [NUM_LEDS-1:0]          led
);
    import myled_pkg::*;

    logic [15:0]          pcnt;
    logic [15:0]          bcnt;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic                 phase;
    logic                 tick;
    logic                 wrap;
    logic [NUM_LEDS-1:0]  pwm;
    logic [NUM_LEDS-1:0]  sel;
    logic [NUM_LEDS-1:0]  mask;

    assign tick = (pcnt == prescale);
    assign wrap = tick && (pwm_cnt == '1);

    always_comb begin
        pwm = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            pwm[i] = duty[i*PWM_BITS +: PWM_BITS] > pwm_cnt;
        end
    end

    assign sel  = pwm_mode ? pwm : direct;
    assign mask = blink_en ? {NUM_LEDS{phase}} : '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            bcnt    <= '0;
            pwm_cnt <= '0;
            phase   <= 1'b0;
            led     <= '0;
        end else begin
            pcnt <= (presc_clr || tick) ? 16'd0 : pcnt + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + {{(PWM_BITS-1){1'b0}}, 1'b1};
            if (wrap) begin
                if (bcnt == blink_period) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 16'd1;
                end
            end
            // enabling blink always restarts in the visible phase
            if (blink_set) phase <= 1'b1;
            led <= en ? (sel & mask) : '0;
        end
    end

endmodule

// File: rtl/myled_pwm_axil.sv
// AXI4-Lite slave and register file for the NUM_LEDS-channel LED driver.
// Define MYLED_SLVERR_EN to answer unmapped accesses with SLVERR.
module myled_pwm_axil #(
    parameter int NUM_LEDS           = 8,
    parameter int PWM_BITS           = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]             LED
);
    import myled_pkg::*;

`ifdef MYLED_SLVERR_EN
    localparam logic [1:0] MISS_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] MISS_RESP = RESP_OKAY;
`endif

    logic                         awready;
    logic                         arready;
    logic                         bvalid;
    logic                         rvalid;
    logic [1:0]                   bresp;
    logic [1:0]                   rresp;
    logic [31:0]                  rdata;
    logic [2:0]                   ctrl;
    logic [NUM_LEDS-1:0]          direct;
    logic [15:0]                  prescale;
    logic [15:0]                  blink_period;
    logic [NUM_LEDS*PWM_BITS-1:0] duty;
    logic [31:0]                  wofs;
    logic [31:0]                  rofs;
    logic [31:0]                  rd_data;
    logic [2:0]                   ctrl_m;
    logic                         wr_en;
    logic                         w_hit;
    logic                         r_hit;
    logic                         presc_clr;
    logic                         blink_set;
    logic                         unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign wofs   = 32'(S_AXI_AWADDR) & ~32'h3;
    assign rofs   = 32'(S_AXI_ARADDR) & ~32'h3;
    assign wr_en  = awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign ctrl_m = 3'(strb_merge(32'(ctrl), S_AXI_WDATA, S_AXI_WSTRB));

    assign presc_clr = wr_en && (wofs == PRESCALE_OFS);
    assign blink_set = wr_en && (wofs == CTRL_OFS) && ctrl_m[CTRL_BLINK];

    always_comb begin
        w_hit = (wofs == CTRL_OFS) || (wofs == DIRECT_OFS) ||
                (wofs == PRESCALE_OFS) || (wofs == BLINK_OFS);
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (wofs == DUTY_BASE + 32'(4*i)) w_hit = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        r_hit   = 1'b1;
        unique case (rofs)
            CTRL_OFS:     rd_data = 32'(ctrl);
            DIRECT_OFS:   rd_data = 32'(direct);
            PRESCALE_OFS: rd_data = 32'(prescale);
            BLINK_OFS:    rd_data = 32'(blink_period);
            default: begin
                r_hit = 1'b0;
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (rofs == DUTY_BASE + 32'(4*i)) begin
                        rd_data = 32'(duty[i*PWM_BITS +: PWM_BITS]);
                        r_hit   = 1'b1;
                    end
                end
            end
        endcase
    end

    // AW and W are taken together, only while no response is pending
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready      <= 1'b0;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            ctrl         <= '0;
            direct       <= '0;
            prescale     <= '0;
            blink_period <= '0;
            duty         <= '0;
        end else begin
            awready <= !awready && S_AXI_AWVALID && S_AXI_WVALID && !bvalid;
            if (wr_en) begin
                bvalid <= 1'b1;
                bresp  <= w_hit ? RESP_OKAY : MISS_RESP;
                unique case (wofs)
                    CTRL_OFS: ctrl <= ctrl_m;
                    DIRECT_OFS: direct <= (NUM_LEDS)'(strb_merge(
                        32'(direct), S_AXI_WDATA, S_AXI_WSTRB));
                    PRESCALE_OFS: prescale <= 16'(strb_merge(
                        32'(prescale), S_AXI_WDATA, S_AXI_WSTRB));
                    BLINK_OFS: blink_period <= 16'(strb_merge(
                        32'(blink_period), S_AXI_WDATA, S_AXI_WSTRB));
                    default: begin
                        for (int i = 0; i < NUM_LEDS; i++) begin
                            if (wofs == DUTY_BASE + 32'(4*i)) begin
                                duty[i*PWM_BITS +: PWM_BITS] <= (PWM_BITS)'(strb_merge(
                                    32'(duty[i*PWM_BITS +: PWM_BITS]),
                                    S_AXI_WDATA, S_AXI_WSTRB));
                            end
                        end
                    end
                endcase
            end else if (S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            arready <= !arready && S_AXI_ARVALID && !rvalid;
            if (arready && S_AXI_ARVALID) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
                rresp  <= r_hit ? RESP_OKAY : MISS_RESP;
            end else if (S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = awready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;

    myled_pwm_core #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS)
    ) u_core (
        .clk          (ACLK),
        .rst_n        (ARESETN),
        .en           (ctrl[CTRL_EN]),
        .pwm_mode     (ctrl[CTRL_PWM]),
        .blink_en     (ctrl[CTRL_BLINK]),
        .direct       (direct),
        .prescale     (prescale),
        .blink_period (blink_period),
        .duty         (duty),
        .presc_clr    (presc_clr),
        .blink_set    (blink_set),
        .led          (LED)
    );

endmodule

// File: tb/tb_myled_pwm_axil.sv
// Self-checking bench for myled_pwm_axil: directed AXI sequences plus
// randomized register settings checked cycle by cycle against a reference model.
module tb_myled_pwm_axil;

    localparam int NL = 8;
    localparam int PB = 8;

`ifdef MYLED_SLVERR_EN
    localparam logic [1:0] MISS = 2'b10;
`else
    localparam logic [1:0] MISS = 2'b00;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [5:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [NL-1:0] led;

    int checks = 0;
    int errors = 0;
    logic led_chk = 1'b0;

    always #5 clk = ~clk;

    myled_pwm_axil #(
        .NUM_LEDS (NL),
        .PWM_BITS (PB)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .LED           (led)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: register contents plus time-based counters
    logic [2:0]  m_ctrl;
    logic [7:0]  m_direct;
    logic [15:0] m_pre;
    logic [15:0] m_bper;
    logic [7:0]  m_duty [NL];
    logic [15:0] m_pcnt;
    logic [7:0]  m_pwm;
    logic [15:0] m_bcnt;
    logic        m_phase;
    logic [7:0]  m_led;

    function automatic logic [31:0] m_rd(input int w);
        case (w)
            0: return {29'b0, m_ctrl};
            1: return {24'b0, m_direct};
            2: return {16'b0, m_pre};
            3: return {16'b0, m_bper};
            default: if (w >= 4 && w < 4 + NL) return {24'b0, m_duty[w-4]};
        endcase
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        logic [7:0]  pw;
        logic [7:0]  nl;
        logic [31:0] nv;
        logic        tick;
        logic        wrap;
        int          w;
        if (!rst_n) begin
            m_ctrl = '0; m_direct = '0; m_pre = '0; m_bper = '0;
            for (int i = 0; i < NL; i++) m_duty[i] = '0;
            m_pcnt = '0; m_pwm = '0; m_bcnt = '0; m_phase = 1'b0; m_led = '0;
        end else begin
            if (led_chk) chk("led", 32'(led), 32'(m_led));
            for (int i = 0; i < NL; i++) pw[i] = m_duty[i] > m_pwm;
            nl = m_ctrl[1] ? pw : m_direct;
            if (m_ctrl[2] && !m_phase) nl = '0;
            if (!m_ctrl[0]) nl = '0;
            tick = (m_pcnt == m_pre);
            wrap = tick && (m_pwm == 8'hFF);
            m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
            if (tick) m_pwm = m_pwm + 8'd1;
            if (wrap) begin
                if (m_bcnt == m_bper) begin
                    m_bcnt = '0;
                    m_phase = !m_phase;
                end else begin
                    m_bcnt = m_bcnt + 16'd1;
                end
            end
            if (awvalid && awready && wvalid && wready) begin
                w = int'(awaddr[5:2]);
                nv = m_rd(w);
                for (int b = 0; b < 4; b++) if (wstrb[b]) nv[8*b +: 8] = wdata[8*b +: 8];
                case (w)
                    0: begin m_ctrl = nv[2:0]; if (nv[2]) m_phase = 1'b1; end
                    1: m_direct = nv[7:0];
                    2: begin m_pre = nv[15:0]; m_pcnt = '0; end
                    3: m_bper = nv[15:0];
                    default: if (w >= 4 && w < 4 + NL) m_duty[w-4] = nv[7:0];
                endcase
            end
            m_led = nl;
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic [1:0] er;
        er = (int'(a[5:2]) < 4 + NL) ? 2'b00 : MISS;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        chk("aw_handshake", 32'(awready & wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("bvalid", 32'(bvalid), 32'd1);
        chk("bresp", 32'(bresp), 32'(er));
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n = 0;
        logic [1:0] er;
        er = (int'(a[5:2]) < 4 + NL) ? 2'b00 : MISS;
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        do begin @(negedge clk); n++; end while (!arready && n < 50);
        chk("ar_handshake", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid", 32'(rvalid), 32'd1);
        chk("rresp", 32'(rresp), 32'(er));
        chk("rdata_model", rdata, m_rd(int'(a[5:2])));
        d = rdata;
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  v;
        int n;
        int c0, c1, c7;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
        chk("rst_valid", 32'({bvalid, rvalid}), 32'd0);
        chk("rst_resp", 32'({bresp, rresp}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        led_chk = 1'b1;

        for (int i = 0; i < 12; i++) begin
            axi_read(6'(4*i), d);
            chk("rst_reg", d, 32'd0);
        end

        axi_write(6'h00, 32'h1, 4'hF);
        axi_write(6'h04, 32'hA5, 4'hF);
        repeat (2) @(negedge clk);
        chk("direct_led", 32'(led), 32'hA5);
        axi_read(6'h04, d);
        chk("direct_rd", d, 32'hA5);
        axi_write(6'h04, 32'hFFFF, 4'h2);
        axi_read(6'h04, d);
        chk("direct_strb", d, 32'hA5);

        axi_write(6'h00, 32'h3, 4'hF);
        axi_write(6'h08, 32'h0, 4'hF);
        axi_write(6'h10, 32'h40, 4'hF);
        axi_write(6'h14, 32'h0, 4'hF);
        axi_write(6'h2C, 32'hFF, 4'hF);
        repeat (3) @(negedge clk);
        c0 = 0; c1 = 0; c7 = 0;
        repeat (256) begin
            @(negedge clk);
            c0 += int'(led[0]); c1 += int'(led[1]); c7 += int'(led[7]);
        end
        chk("pwm_duty40", 32'(c0), 32'd64);
        chk("pwm_duty0", 32'(c1), 32'd0);
        chk("pwm_dutyff", 32'(c7), 32'd255);

        axi_write(6'h08, 32'h0, 4'hF);
        axi_write(6'h0C, 32'h1, 4'hF);
        axi_write(6'h04, 32'hFF, 4'hF);
        axi_write(6'h00, 32'h5, 4'hF);
        chk("blink_start", 32'(led), 32'hFF);
        v = led; n = 0;
        while (led === v && n < 1200) begin @(negedge clk); n++; end
        chk("blink_first_off", 32'(led), 32'h00);
        for (int k = 0; k < 2; k++) begin
            v = led; n = 0;
            while (led === v && n < 1200) begin @(negedge clk); n++; end
            chk("blink_run", 32'(n), 32'd512);
        end

        @(posedge clk); #1;
        awaddr = 6'h04; wdata = 32'h3C; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("aw_only_wait", 32'(awready | wready), 32'd0);
        end
        @(posedge clk); #1;
        wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        chk("both_ready", 32'(awready & wready), 32'd1);
        @(posedge clk); #1;
        wdata = 32'h5A;
        repeat (4) begin
            @(negedge clk);
            chk("b_hold", 32'({bvalid, awready, wready}), 32'b100);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        chk("second_aw", 32'(awready & wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("second_b", 32'(bvalid), 32'd1);
        @(posedge clk); #1;
        bready = 1'b0;
        axi_read(6'h04, d);
        chk("second_data", d, 32'h5A);

        awaddr = 6'h04; wdata = 32'h33; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 6'h04; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 50);
        chk("rw_same_ar", 32'({awready, arready}), 32'b11);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("rw_same_old", rdata, 32'h5A);
        chk("rw_same_b", 32'({bvalid, rvalid}), 32'b11);
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        axi_read(6'h04, d);
        chk("rw_same_new", d, 32'h33);

        axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF);
        axi_read(6'h3C, d);
        chk("unmapped_rd", d, 32'd0);
        axi_read(6'h04, d);
        chk("unmapped_nowr", d, 32'h33);

        for (int it = 0; it < 4; it++) begin
            axi_write(6'h08, 32'($urandom_range(0, 2)), 4'hF);
            axi_write(6'h0C, 32'($urandom_range(0, 3)), 4'hF);
            axi_write(6'h04, $urandom, 4'hF);
            for (int i = 0; i < NL; i++) begin
                axi_write(6'(16 + 4*i), $urandom, 4'($urandom_range(0, 15)));
            end
            axi_write(6'h00, 32'($urandom_range(0, 7)), 4'hF);
            repeat (700) @(negedge clk);
            for (int i = 0; i < 12; i++) axi_read(6'(4*i), d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/myled_pwm_axil.md
Name: myled_pwm_axil

Overview:
Parametrised successor to the 8-LED AXI4-Lite register peripheral. It exposes a NUM_LEDS-channel LED driver as an AXI4-Lite slave. Each channel has direct on/off control or PWM dimming, plus an optional global blink gate. It sits behind the PS/interconnect AXI4-Lite master and drives board LEDs directly.

Parameters:
NUM_LEDS, 8, number of LED channels (1..8)
PWM_BITS, 8, PWM counter and duty width (4..16)
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 6, AXI byte-address width (64-byte window)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
LED  out  NUM_LEDS  registered LED drive, 1 = on

Behaviour:
- Reset (ARESETN low, async): all registers 0, all READY/VALID 0, BRESP/RRESP 0, RDATA 0, LED 0, all counters and blink phase 0.
- Register map, word-aligned, addr[1:0] ignored:
  - 0x00 CTRL: [0] EN, [1] PWM_MODE, [2] BLINK_EN.
  - 0x04 DIRECT: [NUM_LEDS-1:0].
  - 0x08 PRESCALE: [15:0].
  - 0x0C BLINK_PERIOD: [15:0].
  - 0x10+4*i DUTY[i]: [PWM_BITS-1:0], i < NUM_LEDS.
  - Unused bits read 0.
- Write channel:
  - Accept only when AWVALID and WVALID are both high and BVALID is low.
  - AWREADY and WREADY pulse high together for one cycle. The register updates on that edge, per WSTRB byte.
  - BVALID rises the next cycle and holds until BREADY. BRESP = OKAY.
  - At most one write outstanding. AW without W (or W without AW) waits with no READY.
- Read channel:
  - ARREADY pulses one cycle when ARVALID is high and RVALID is low.
  - RDATA/RVALID are registered the next cycle and held stable until RREADY.
  - At most one read outstanding.
- Read and write proceed independently. A same-cycle read and write to the same register returns the old value.
- Unmapped address (including DUTY index >= NUM_LEDS): write discarded, read returns 0, response OKAY.
- Prescaler:
  - 16-bit counter runs 0..PRESCALE. tick = (cnt == PRESCALE), then cnt returns to 0.
  - PRESCALE = 0 gives tick every cycle.
  - A write to PRESCALE resets cnt to 0.
- PWM:
  - PWM_BITS counter increments on tick and wraps. wrap = tick and counter at all-ones.
  - pwm[i] = DUTY[i] > pwm_cnt. DUTY = 0 is always off; DUTY = max is on for (2^PWM_BITS - 1) of 2^PWM_BITS steps.
- Blink:
  - 16-bit counter increments on wrap. When it equals BLINK_PERIOD and wrap occurs, the counter clears and the phase toggles.
  - BLINK_PERIOD = 0 toggles the phase on every wrap.
  - Phase resets to 1 (visible) on any CTRL write that sets BLINK_EN.
- Output, registered (one cycle latency from counter/register state):
  - LED = EN ? ((PWM_MODE ? pwm : DIRECT) & (BLINK_EN ? {NUM_LEDS{phase}} : all-ones)) : 0.
- Clearing EN forces LED to 0 on the next edge; counters keep running.

Optional Feature:
- MYLED_SLVERR_EN defined: unmapped writes and reads return SLVERR (2'b10) on BRESP/RRESP. Unmapped reads still return RDATA 0. The handshake is unchanged.
- Not defined: all responses are OKAY.

Decomposition:
- Package myled_pkg holds:
  - Register offset localparams (CTRL_OFS, DIRECT_OFS, PRESCALE_OFS, BLINK_OFS, DUTY_BASE).
  - CTRL bit indices.
  - RESP_OKAY / RESP_SLVERR constants.
- One sub-module, myled_pwm_core, holds the prescaler, PWM counter, blink logic and LED register. The top-level holds the AXI4-Lite slave and the register file.

Test Plan:
- Reset then read all 12 registers -> every RDATA = 0x0, LED = 0, RRESP OKAY.
- Write CTRL = 0x1, DIRECT = 0xA5; wait 2 cycles -> LED = 0xA5. Read DIRECT back -> 0x000000A5. Write WSTRB = 0x2 with data 0xFFFF -> DIRECT unchanged, 0xA5.
- CTRL = 0x3, PRESCALE = 0, DUTY[0] = 0x40, DUTY[1] = 0, DUTY[7] = 0xFF; count LED over 256 cycles -> LED[0] high 64 cycles, LED[1] 0 cycles, LED[7] 255 cycles.
- CTRL = 0x5, DIRECT = 0xFF, PRESCALE = 0, BLINK_PERIOD = 1 -> LED toggles 0xFF/0x00 every 512 cycles, starting with 0xFF.
- Issue AWVALID 3 cycles before WVALID, and hold BREADY low 4 cycles -> AWREADY/WREADY pulse only once both are valid; BVALID held 4 cycles; no second write accepted meanwhile.
- Write to and read from 0x3C -> write ignored, RDATA 0. RESP = OKAY, or SLVERR when MYLED_SLVERR_EN is defined.
